// File: rtl/seq_detect_param.sv
// Serial pattern detector with a loadable PAT_W-bit pattern and a same-cycle Mealy match flag.
// Optional saturating match counter enabled by defining MATCH_CNT_EN.
module seq_detect_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(3'b101),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_valid,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap,
    output logic             q
`ifdef MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    localparam int               FW   = $clog2(PAT_W);
    localparam logic [FW-1:0]    FMAX = FW'(PAT_W - 1);

    logic [PAT_W-1:0] pat;
    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] shifted;
    logic             hit;

    // A full window is the PAT_W-1 stored bits plus the bit arriving this cycle.
    assign shifted = {hist, in};
    assign hit     = (fill == FMAX) && (shifted == pat);
    assign q       = in_valid && !load && !rst && hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat  <= RST_PAT;
            hist <= '0;
            fill <= '0;
        end else if (load) begin
            pat  <= pattern_in;
            fill <= '0;
        end else if (in_valid) begin
            hist <= shifted[PAT_W-2:0];
            if (hit && !overlap)
                fill <= '0;
            else if (fill != FMAX)
                fill <= fill + 1'b1;
        end
    end

`ifdef MATCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            match_cnt <= '0;
        else if (q && (match_cnt != {CNT_W{1'b1}}))
            match_cnt <= match_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: a default 3-bit instance and a 4-bit instance
// driven by the same serial stimulus; counter checks only when MATCH_CNT_EN is defined.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       load = 1'b0;
    logic       overlap = 1'b1;
    logic [2:0] pattern_in3 = 3'b101;
    logic [3:0] pattern_in4 = 4'b0000;
    logic       q3, q4;
`ifdef MATCH_CNT_EN
    logic [1:0] cnt3;
    logic [7:0] cnt4;
`endif

    int checks = 0;
    int errors = 0;

    seq_detect_param #(.PAT_W(3), .RST_PAT(3'b101), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .load(load),
        .pattern_in(pattern_in3), .overlap(overlap), .q(q3)
`ifdef MATCH_CNT_EN
        , .match_cnt(cnt3)
`endif
    );

    seq_detect_param #(.PAT_W(4), .RST_PAT(4'b1001), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .load(load),
        .pattern_in(pattern_in4), .overlap(overlap), .q(q4)
`ifdef MATCH_CNT_EN
        , .match_cnt(cnt4)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic apply(input logic v, input logic b, input logic ld);
        @(negedge clk);
        rst = 1'b0; in_valid = v; in = b; load = ld;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; in = 1'b1; load = 1'b0;
        #1;
        chk("q3_in_reset", q3, 1'b0);
        chk("q4_in_reset", q4, 1'b0);
    endtask

    logic [8:0] stream9;
    logic [8:0] q_exp9;
    logic [8:0] c_exp9;  // bit i set means expected cnt before bit i is given by the table below
    logic [1:0] cnt_tab [9];
    logic [4:0] stream5;
    logic [4:0] q_exp5;

    initial begin
        // Overlapping stream 1,0,1,0,1,0,1,0,1: matches on bits 3,5,7,9, counter saturates at 3.
        do_reset();
`ifdef MATCH_CNT_EN
        @(negedge clk); #1;
        chk("cnt_after_reset", cnt3, 2'd0);
`endif
        overlap  = 1'b1;
        stream9  = 9'b101010101;
        q_exp9   = 9'b001010101;
        cnt_tab  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 9; i++) begin
            apply(1'b1, stream9[8-i], 1'b0);
            chk($sformatf("ovl_q_bit%0d", i + 1), q3, q_exp9[8-i]);
`ifdef MATCH_CNT_EN
            chk($sformatf("ovl_cnt_bit%0d", i + 1), cnt3, cnt_tab[i]);
`endif
        end
        apply(1'b0, 1'b0, 1'b0);
        chk("gap_q", q3, 1'b0);
`ifdef MATCH_CNT_EN
        chk("cnt_saturated", cnt3, 2'd3);
`endif

        // Non-overlapping stream 1,0,1,0,1: only the 3rd bit matches.
        do_reset();
        overlap = 1'b0;
        stream5 = 5'b10101;
        q_exp5  = 5'b00100;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, stream5[4-i], 1'b0);
            chk($sformatf("novl_q_bit%0d", i + 1), q3, q_exp5[4-i]);
        end

        // Reset mid-sequence clears history.
        overlap = 1'b1;
        do_reset();
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        do_reset();
        apply(1'b1, 1'b1, 1'b0);
        chk("post_rst_bit1", q3, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        chk("post_rst_bit2", q3, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        chk("post_rst_bit3", q3, 1'b1);

        // Load with a simultaneous valid bit: bit dropped, fill cleared, counter kept.
        do_reset();
        apply(1'b1, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        chk("pre_load_match", q3, 1'b1);
        apply(1'b1, 1'b0, 1'b0);
        pattern_in3 = 3'b101;
        apply(1'b1, 1'b1, 1'b1);
        chk("load_q", q3, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        chk("after_load_bit1", q3, 1'b0);
`ifdef MATCH_CNT_EN
        chk("cnt_kept_by_load", cnt3, 2'd1);
`endif
        apply(1'b1, 1'b0, 1'b0);
        chk("after_load_bit2", q3, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        chk("after_load_bit3", q3, 1'b1);

        // 4-bit instance: load 1101, feed 1,1,0,1 with idle cycles in between.
        do_reset();
        pattern_in4 = 4'b1101;
        apply(1'b0, 1'b0, 1'b1);
        stream5 = 5'b01101;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, stream5[3-i], 1'b0);
            chk($sformatf("p4_q_bit%0d", i + 1), q4, (i == 3) ? 1'b1 : 1'b0);
            apply(1'b0, 1'b1, 1'b0);
            chk($sformatf("p4_q_gap%0d", i + 1), q4, 1'b0);
        end
        // Overlap on: trailing 1 plus 1,0,1 forms 1101 again.
        apply(1'b1, 1'b1, 1'b0);
        chk("p4_ovl_b1", q4, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        chk("p4_ovl_b2", q4, 1'b0);
        apply(1'b1, 1'b1, 1'b0);
        chk("p4_ovl_b3", q4, 1'b1);

        @(negedge clk);
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 3, pattern length in bits, legal range 2..16.
REQ-002 Parameter RST_PAT, default 3'b101 (PAT_W bits), pattern loaded at reset.
REQ-003 Parameter CNT_W, default 8, match-counter width, legal range 1..32.
REQ-004 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port in  input  1  serial data bit.
REQ-007 Port in_valid  input  1  in is consumed only on cycles with in_valid=1.
REQ-008 Port load  input  1  pattern-load strobe.
REQ-009 Port pattern_in  input  PAT_W  new pattern; MSB = first bit received.
REQ-010 Port overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
REQ-011 Port q  output  1  Mealy match flag, combinational.
REQ-012 Port match_cnt  output  CNT_W  saturating match count (present only with MATCH_CNT_EN).

Function
REQ-013 State: pat register (PAT_W), hist shift register (PAT_W-1 bits, newest bit in LSB), fill counter (0..PAT_W-1) = number of valid hist bits.
REQ-014 q SHALL be 1 iff in_valid=1, load=0, rst=0, fill=PAT_W-1, and {hist, in} == pat; otherwise 0 (same-cycle, zero latency).
REQ-015 On in_valid=1 with no match: hist shifts left taking in; fill increments, saturating at PAT_W-1.
REQ-016 On a match with overlap=1: hist shifts in the bit as in REQ-015; fill stays PAT_W-1, so a match can recur in the next valid cycle.
REQ-017 On a match with overlap=0: fill clears to 0; the next match needs PAT_W fresh valid bits.
REQ-018 in_valid=0: hist, fill, counter hold; q=0.
REQ-019 load=1: pat <= pattern_in, fill <= 0 next cycle; a simultaneous in_valid bit is discarded and q=0.
REQ-020 overlap is sampled per match cycle; changing it mid-stream affects only subsequent matches.
REQ-021 Bits seen before fill reaches PAT_W-1 SHALL NOT produce matches (no partial-history matches after reset/load).

Reset
REQ-022 rst=1 at posedge clk: pat <= RST_PAT, hist <= 0, fill <= 0, match_cnt <= 0.
REQ-023 rst has priority over load and in_valid; q=0 while rst=1.
REQ-024 Reset mid-sequence discards all history; detection restarts from an empty history.

Configuration
REQ-025 Macro MATCH_CNT_EN defined: match_cnt increments by 1 on each cycle q=1, saturating at 2^CNT_W-1; load SHALL NOT clear it; only rst clears it.
REQ-026 Macro MATCH_CNT_EN undefined: match_cnt port and counter logic absent; all other behaviour unchanged.

Verification
REQ-027 Defaults, rst then in_valid=1, in stream 1,0,1,0,1 overlap=1 -> q=1 on 3rd and 5th bits only.
REQ-028 Same stream, overlap=0 -> q=1 on 3rd bit only; 5th bit q=0.
REQ-029 PAT_W=4, load pattern_in=4'b1101, stream 1,1,0,1 with in_valid gaps (0 between each bit) -> q=1 on the 4th valid bit, never on gap cycles.
REQ-030 Stream 1,0 then rst=1 one cycle, then 1 -> q=0 (history cleared); then 0,1 -> q=1.
REQ-031 load=1 with in_valid=1, in=1 when hist=2'b10 -> q=0, bit discarded, fill=0 next cycle.
REQ-032 MATCH_CNT_EN, CNT_W=2, overlap=1, stream 1,0,1,0,1,0,1,0,1 (4 matches) -> match_cnt 1,2,3,3 (saturates at 3).
